// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
//   req       : request vector, bit i is requester i
//   done      : release from the current grant holder
//   gnt       : one-hot (or zero) grant vector
//   gnt_valid : high exactly when gnt is non-zero
//   timeout   : single-cycle pulse on a hold-timer forced release
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  // Requester side
  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  timeout
  );

  // Arbiter side
  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant and an
// optional hold timer that force-releases a holder that never signals done.
//   MAX_HOLD : maximum grant length in cycles (0..255), 0 disables the timer
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : rr_arbiter8_if.slave (req/done in, gnt/gnt_valid/timeout out)
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter8_if.slave  bus
);

  localparam int unsigned N_REQ   = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 8;
  localparam bit          HOLD_EN = (MAX_HOLD != 0);
  // Only meaningful when HOLD_EN; the truncation for MAX_HOLD = 0 is unused.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q,  state_d;
  logic [IDX_W-1:0]   ptr_q,    ptr_d;
  logic [IDX_W-1:0]   owner_q,  owner_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [N_REQ-1:0]   gnt_q,    gnt_d;
  logic               gv_q,     gv_d;
  logic               to_q,     to_d;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W-1:0]   sel;

  // Rotate req so that bit ptr lands at position 0, then pick the lowest set bit.
  always_comb begin
    req_dbl = {bus.req, bus.req} >> ptr_q;
    req_rot = req_dbl[N_REQ-1:0];
    off     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = IDX_W'(i);
    end
    sel = ptr_q + off;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      gv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      gv_q    <= gv_d;
      to_q    <= to_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    gv_d    = gv_q;
    to_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          owner_d = sel;
          gnt_d   = N_REQ'(1) << sel;
          gv_d    = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (bus.done || (HOLD_EN && (cnt_q == HOLD_LAST))) begin
          // A simultaneous done wins, so the timeout pulse is suppressed.
          to_d    = !bus.done;
          gnt_d   = '0;
          gv_d    = 1'b0;
          ptr_d   = owner_q + IDX_W'(1);
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gv_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: three instances (MAX_HOLD = 16, 4, 0) share one
// stimulus stream; a behavioural model per instance is compared every cycle,
// and directed hand-computed expectations pin the model.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rr_arbiter8_if b16 ();
  rr_arbiter8_if b4 ();
  rr_arbiter8_if b0 ();

  assign b16.req = req;  assign b16.done = done;
  assign b4.req  = req;  assign b4.done  = done;
  assign b0.req  = req;  assign b0.done  = done;

  rr_arbiter8 #(.MAX_HOLD(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  rr_arbiter8 #(.MAX_HOLD(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  rr_arbiter8 #(.MAX_HOLD(0))  u0  (.clk(clk), .rst_n(rst_n), .bus(b0));

  function automatic int mh(input int i);
    return (i == 0) ? 16 : (i == 1) ? 4 : 0;
  endfunction

  logic [7:0] d_gnt [3];
  logic       d_gv  [3];
  logic       d_to  [3];
  assign d_gnt[0] = b16.gnt; assign d_gv[0] = b16.gnt_valid; assign d_to[0] = b16.timeout;
  assign d_gnt[1] = b4.gnt;  assign d_gv[1] = b4.gnt_valid;  assign d_to[1] = b4.timeout;
  assign d_gnt[2] = b0.gnt;  assign d_gv[2] = b0.gnt_valid;  assign d_to[2] = b0.timeout;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who is granted, for how many cycles so far.
  bit         m_busy  [3] = '{0, 0, 0};
  int         m_ptr   [3] = '{0, 0, 0};
  int         m_owner [3] = '{0, 0, 0};
  int         m_len   [3] = '{0, 0, 0};
  logic [7:0] m_gnt   [3] = '{8'h00, 8'h00, 8'h00};
  bit         m_to    [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    bit found;
    int b;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_ptr[i] = 0; m_owner[i] = 0;
        m_len[i] = 0;  m_gnt[i] = 8'h00; m_to[i] = 0;
      end else begin
        m_to[i] = 0;
        if (!m_busy[i]) begin
          found = 0;
          for (int k = 0; k < 8; k++) begin
            b = (m_ptr[i] + k) % 8;
            if (!found && req[b]) begin
              found = 1;
              m_owner[i] = b;
            end
          end
          if (found) begin
            m_busy[i] = 1;
            m_len[i]  = 1;
            m_gnt[i]  = 8'h00;
            m_gnt[i][m_owner[i]] = 1'b1;
          end
        end else if (done || (mh(i) != 0 && m_len[i] == mh(i))) begin
          m_to[i]   = !done;
          m_busy[i] = 0;
          m_gnt[i]  = 8'h00;
          m_ptr[i]  = (m_owner[i] + 1) % 8;
        end else begin
          m_len[i]++;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus one-hot / valid consistency.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d gnt", mh(i)), d_gnt[i], m_gnt[i]);
      chk($sformatf("u%0d gnt_valid", mh(i)), 8'(d_gv[i]), 8'(m_gnt[i] != 8'h00));
      chk($sformatf("u%0d timeout", mh(i)), 8'(d_to[i]), 8'(m_to[i]));
      chk($sformatf("u%0d onehot", mh(i)), 8'($countones(d_gnt[i]) <= 1), 8'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rot_seq [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    // Reset then single request
    step(); step(); step();
    chk("reset gnt", b16.gnt, 8'h00);
    chk("reset timeout", 8'(b16.timeout), 8'h00);
    rst_n = 1'b1;
    req   = 8'h10;
    step();
    chk("single gnt", b16.gnt, 8'h10);
    chk("single gnt_valid", 8'(b16.gnt_valid), 8'h01);
    done = 1'b1;
    step();
    chk("single release", b16.gnt, 8'h00);
    done = 1'b0;
    step();
    chk("single regrant", b16.gnt, 8'h10);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    step();

    // Rotation with wrap from ptr = 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("rot grant %0d", i), b16.gnt, rot_seq[i]);
      done = 1'b1;
      step();
      chk($sformatf("rot gap %0d", i), b16.gnt, 8'h00);
      done = 1'b0;
    end

    // Pointer skip and wrap
    req = 8'h20;
    step();
    chk("skip grant5", b16.gnt, 8'h20);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h03;
    step();
    chk("skip wrap", b16.gnt, 8'h01);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk("skip next", b16.gnt, 8'h02);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    step();

    // Timeout: 4-cycle limit, 16-cycle limit, and disabled timer
    req = 8'h08;
    step();
    chk("to grant", b4.gnt, 8'h08);
    req = 8'h00;
    for (int j = 1; j <= 3; j++) begin
      step();
      chk($sformatf("to hold %0d", j), b4.gnt, 8'h08);
    end
    step();
    chk("to release", b4.gnt, 8'h00);
    chk("to pulse", 8'(b4.timeout), 8'h01);
    step();
    chk("to pulse end", 8'(b4.timeout), 8'h00);
    for (int j = 6; j <= 300; j++) begin
      step();
      if (j == 15) chk("to16 hold", b16.gnt, 8'h08);
      if (j == 16) begin
        chk("to16 release", b16.gnt, 8'h00);
        chk("to16 pulse", 8'(b16.timeout), 8'h01);
      end
    end
    chk("no-timer hold", b0.gnt, 8'h08);
    chk("no-timer timeout", 8'(b0.timeout), 8'h00);
    done = 1'b1;
    step();
    done = 1'b0;
    step();

    // Done coincident with the timeout condition
    req = 8'h08;
    step();
    req = 8'h00;
    step(); step(); step();
    done = 1'b1;
    step();
    chk("sim release", b4.gnt, 8'h00);
    chk("sim timeout", 8'(b4.timeout), 8'h00);
    done = 1'b0;
    step();
    chk("sim timeout after", 8'(b4.timeout), 8'h00);

    // Asynchronous reset mid-grant
    req = 8'h40;
    step();
    chk("async pre", b16.gnt, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async gnt16", b16.gnt, 8'h00);
    chk("async gnt4", b4.gnt, 8'h00);
    chk("async gnt0", b0.gnt, 8'h00);
    chk("async valid", 8'(b16.gnt_valid), 8'h00);
    req = 8'hFF;
    step();
    rst_n = 1'b1;
    step();
    chk("post-reset grant", b16.gnt, 8'h01);
    chk("post-reset grant0", b0.gnt, 8'h01);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that produces a registered, strictly one-hot grant vector. It sits directly upstream of the team's 8-to-3 encoder: `gnt` drives the encoder input, so the encoder only ever sees zero or a single set bit. A hold timer optionally force-releases a requester that never signals completion.

## Interface
- `MAX_HOLD`, default 16: maximum grant length in cycles, legal range 0..255. A value of 0 disables the timeout.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req`  input  8  request vector; bit i is requester i; any number of bits may be set.
- `done`  input  1  release from the current grant holder; sampled only in GRANT.
- `gnt`  output  8  registered grant; either all zero or exactly one bit set.
- `gnt_valid`  output  1  high exactly when `gnt` is non-zero.
- `timeout`  output  1  one-cycle pulse when a grant is force-released by the hold timer.

## Operation
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - 3-bit priority pointer `ptr`.
  - 3-bit `owner` index.
  - 8-bit `hold_cnt`.
- Reset values:
  - `gnt` = 0, `gnt_valid` = 0, `timeout` = 0.
  - state = IDLE, `ptr` = 0, `owner` = 0, `hold_cnt` = 0.
  - Reset applies immediately, including mid-grant; `gnt` drops without waiting for a clock edge.
- IDLE:
  - If `req` = 0, remain in IDLE.
  - Otherwise, select the first set bit searching upward from `ptr` and wrapping modulo 8. Example: `ptr` = 6, `req` = 8'b0000_0011 selects bit 0.
  - Load `owner` with the selected index, set `gnt` to 1 << owner, set `hold_cnt` = 0, and go to GRANT.
- GRANT, evaluated at each rising edge:
  - If `done` = 1, release.
  - Otherwise, if `MAX_HOLD` != 0 and `hold_cnt` == `MAX_HOLD` - 1, release and pulse `timeout` for one cycle.
  - Otherwise, `hold_cnt` += 1 and `gnt` holds.
- Release:
  - `gnt` = 0, `ptr` = `owner` + 1 (mod 8, wraps 7 to 0), state = IDLE.
- Simultaneous `done` and timeout condition: treated as a normal done release; `timeout` stays low.
- Grant holding:
  - `req[owner]` deasserting during GRANT does not release the grant; only `done` or the timeout releases it.
  - Changes to other `req` bits during GRANT are ignored.
- `done` in IDLE is ignored.
- `gnt` never has more than one bit set; this holds across every transition and reset.

## Timing
- Grant latency: `req` sampled in IDLE at edge k gives `gnt` valid after edge k, with one register stage and no combinational path from `req` to `gnt`.
- Grant visibility: `gnt` stays constant from the grant edge through the edge at which release is sampled, and is 0 after that edge.
- Mandatory gap: at least one IDLE cycle (`gnt` = 0) separates consecutive grants, even to the same requester.
- Minimum grant: 1 cycle, when `done` is high at the first GRANT edge.
- Maximum grant: `MAX_HOLD` cycles when the timer is enabled.
- Timeout pulse: `timeout` is high for the single cycle immediately following the forced-release edge, coincident with the first `gnt` = 0 cycle.
- Round-robin fairness: with all 8 bits of `req` held high and `done` pulsed once per grant, grants rotate 0,1,...,7,0. Each grant period is grant length + 1 idle cycle.

## Test plan
- Reset then single request:
  - Stimulus: `rst_n` low for 3 cycles, then `req` = 8'h10.
  - Response: `gnt` = 8'h10 and `gnt_valid` = 1 one edge later.
  - Then `done` = 1 for one cycle: `gnt` = 0 after that edge; next grant to requester 4 appears one idle cycle later.
- Rotation with wrap:
  - Stimulus: `req` = 8'hFF held, `done` pulsed every grant.
  - Response: grant sequence 8'h01, 02, 04, 08, 10, 20, 40, 80, 01, with `gnt` = 0 between each pair.
- Pointer skip and wrap:
  - Stimulus: after a grant to bit 5 (`ptr` = 6), apply `req` = 8'h03.
  - Response: `gnt` = 8'h01; after release, `ptr` = 1 and the next grant is 8'h02.
- Timeout:
  - Stimulus: `MAX_HOLD` = 4, `req` = 8'h08, `done` held low.
  - Response: `gnt` = 8'h08 for exactly 4 cycles, then `gnt` = 0 with `timeout` = 1 for 1 cycle.
  - Stimulus: `MAX_HOLD` = 0 with the same inputs.
  - Response: the grant is held for 300 cycles without release and `timeout` stays 0.
- Simultaneous done and timeout:
  - Stimulus: `MAX_HOLD` = 4, `done` asserted on the 4th grant cycle.
  - Response: release occurs and `timeout` stays 0.
- Asynchronous reset mid-grant:
  - Stimulus: assert `rst_n` low between clock edges while `gnt` = 8'h40.
  - Response: `gnt` = 0 immediately; after deassert, `req` = 8'hFF grants 8'h01 (`ptr` = 0).
  - Check: one-hot checker on `gnt` passes throughout all scenarios.
